// File: rtl/gcd_operand_mux.sv
// ---------------------------------------------------------------------------
// gcd_operand_mux
//
// Purpose: operand staging for an iterative GCD engine. Two operands arrive
// one after another on a shared load bus (A first, then B). Once both are
// held, a small command set (HOLD / SUB / SWAP / RELEASE) rewrites them in
// place. A sticky err flag records any SUB that underflowed (A < B).
//
// Handshake: an operand transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is 1 only while fewer than two operands are
// held. cmd is acted on only while op_valid is 1 (both operands held); in
// that state in_valid is ignored.
//
// Parameters:
//   WIDTH    operand width, 2..32
//   RST_VAL  value loaded into both operand registers on rst and clr
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   clr          synchronous flush back to EMPTY (below rst)
//   data_in      shared operand load bus
//   in_valid     data_in holds an operand
//   in_ready     an operand is accepted this cycle
//   cmd          00 HOLD, 01 SUB, 10 SWAP, 11 RELEASE
//   a_out        operand register A
//   b_out        operand register B
//   op_valid     both operands loaded, cmd is honoured
//   a_lt_b       A < B (unsigned)
//   b_zero       B == 0
//   err          sticky SUB-underflow flag
//   dbg_state_o  current FSM state (0 EMPTY, 1 HALF, 2 FULL)
//
// Build option: macro GCD_OPMUX_FLAGS_EN. When it is defined, a_lt_b and
// b_zero are registers loaded from the next-state operands, so they line up
// with a_out/b_out in the same cycle. When it is undefined, both flags are
// tied to 0 and no comparator is built; err works either way.
// ---------------------------------------------------------------------------
module gcd_operand_mux #(
   parameter int          WIDTH   = 8,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       cmd,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             op_valid,
   output logic             a_lt_b,
   output logic             b_zero,
   output logic             err,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_e;

   localparam logic [1:0] CMD_HOLD    = 2'b00;
   localparam logic [1:0] CMD_SUB     = 2'b01;
   localparam logic [1:0] CMD_SWAP    = 2'b10;
   localparam logic [1:0] CMD_RELEASE = 2'b11;

   localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             err_q, err_d;
   logic             in_ready_q;
   logic             op_valid_q;

   // Next-state for operands, state and err. rst is applied in the register
   // block so that it outranks clr.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      if (clr) begin
         state_d = EMPTY;
         a_d     = RST_W;
         b_d     = RST_W;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_valid) begin
                  a_d     = data_in;
                  state_d = HALF;
               end
            end
            HALF: begin
               if (in_valid) begin
                  b_d     = data_in;
                  state_d = FULL;
               end
            end
            FULL: begin
               case (cmd)
                  CMD_HOLD: ;
                  CMD_SUB: begin
                     // Subtraction wraps naturally at WIDTH bits; the
                     // underflow is remembered in err.
                     a_d = a_q - b_q;
                     if (a_q < b_q) err_d = 1'b1;
                  end
                  CMD_SWAP: begin
                     a_d = b_q;
                     b_d = a_q;
                  end
                  CMD_RELEASE: begin
                     state_d = EMPTY;
                     err_d   = 1'b0;
                  end
                  default: ;
               endcase
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Single state register block; handshake outputs are registered from the
   // next state so they never lag the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         a_q        <= RST_W;
         b_q        <= RST_W;
         err_q      <= 1'b0;
         in_ready_q <= 1'b1;
         op_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         err_q      <= err_d;
         in_ready_q <= (state_d != FULL);
         op_valid_q <= (state_d == FULL);
      end
   end

`ifdef GCD_OPMUX_FLAGS_EN
   logic a_lt_b_q;
   logic b_zero_q;

   // Flags are computed from the values A/B are about to take, so they are
   // valid in the same cycle as the operands they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_lt_b_q <= 1'b0;
         b_zero_q <= (RST_W == '0);
      end else begin
         a_lt_b_q <= (a_d < b_d);
         b_zero_q <= (b_d == '0);
      end
   end

   assign a_lt_b = a_lt_b_q;
   assign b_zero = b_zero_q;
`else
   assign a_lt_b = 1'b0;
   assign b_zero = 1'b0;
`endif

   assign in_ready    = in_ready_q;
   assign op_valid    = op_valid_q;
   assign a_out       = a_q;
   assign b_out       = b_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gcd_operand_mux.sv
// ---------------------------------------------------------------------------
// tb_gcd_operand_mux
//
// Bench for gcd_operand_mux at WIDTH=8, RST_VAL=0. A reference model keeps
// the held operands as a count of loaded values plus A, B and err, and is
// advanced once per clock from the same inputs given to the DUT. Directed
// sequences cover the worked examples; a randomized run follows.
// ---------------------------------------------------------------------------
module tb_gcd_operand_mux;

   localparam int W = 8;

   // clock / reset
   logic         clk;
   logic         rst;
   logic         clr;
   logic [W-1:0] data_in;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   cmd;
   logic [W-1:0] a_out;
   logic [W-1:0] b_out;
   logic         op_valid;
   logic         a_lt_b;
   logic         b_zero;
   logic         err;
   logic [1:0]   dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   gcd_operand_mux #(.WIDTH(W), .RST_VAL(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .data_in     (data_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cmd         (cmd),
      .a_out       (a_out),
      .b_out       (b_out),
      .op_valid    (op_valid),
      .a_lt_b      (a_lt_b),
      .b_zero      (b_zero),
      .err         (err),
      .dbg_state_o (dbg_state)
   );

   // scoreboard
   int n_vec;
   int n_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: how many operands are held, their values, and err
   int       m_cnt;
   int       m_a;
   int       m_b;
   bit       m_err;

   task automatic model_step(input bit r, input bit c, input bit v,
                             input int d, input int k);
      int old_a;
      if (r || c) begin
         m_cnt = 0; m_a = 0; m_b = 0; m_err = 0;
      end else if (m_cnt < 2) begin
         if (v) begin
            if (m_cnt == 0) m_a = d; else m_b = d;
            m_cnt++;
         end
      end else begin
         case (k)
            1: begin
               if (m_a < m_b) m_err = 1;
               m_a = (m_a - m_b + 256) % 256;
            end
            2: begin
               old_a = m_a; m_a = m_b; m_b = old_a;
            end
            3: begin
               m_cnt = 0; m_err = 0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ".a_out"},    a_out,    m_a);
      check({ctx, ".b_out"},    b_out,    m_b);
      check({ctx, ".op_valid"}, op_valid, (m_cnt == 2));
      check({ctx, ".in_ready"}, in_ready, (m_cnt < 2));
      check({ctx, ".err"},      err,      m_err);
`ifdef GCD_OPMUX_FLAGS_EN
      check({ctx, ".a_lt_b"},   a_lt_b,   (m_a < m_b));
      check({ctx, ".b_zero"},   b_zero,   (m_b == 0));
`else
      check({ctx, ".a_lt_b"},   a_lt_b,   0);
      check({ctx, ".b_zero"},   b_zero,   0);
`endif
   endtask

   // driver: one clock of stimulus, then model update and full check
   task automatic apply(input string ctx, input bit r, input bit c, input bit v,
                        input int d, input int k);
      @(negedge clk);
      rst      = r;
      clr      = c;
      in_valid = v;
      data_in  = W'(d);
      cmd      = 2'(k);
      @(posedge clk);
      model_step(r, c, v, d, k);
      #1;
      check_all(ctx);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; data_in = '0; cmd = 2'b00;
      n_vec = 0; n_bad = 0;
      m_cnt = 0; m_a = 0; m_b = 0; m_err = 0;

      // reset, then load 48 and 18
      apply("rst",   1, 0, 0, 0, 0);
      check("rst.in_ready_const", in_ready, 1);
      apply("ldA",   0, 0, 1, 48, 0);
      apply("ldB",   0, 0, 1, 18, 0);
      check("ld.op_valid_const", op_valid, 1);
      check("ld.a_const", a_out, 48);
      check("ld.b_const", b_out, 18);

      // SUB, SUB, SWAP
      apply("sub1",  0, 0, 0, 0, 1);
      check("sub1.a_const", a_out, 30);
      apply("sub2",  0, 0, 0, 0, 1);
      check("sub2.a_const", a_out, 12);
      apply("swap",  0, 0, 0, 0, 2);
      check("swap.a_const", a_out, 18);
      check("swap.b_const", b_out, 12);
      check("swap.err_const", err, 0);

      // underflow, sticky err, RELEASE clears it
      apply("rst2",  1, 0, 0, 0, 0);
      apply("ld5",   0, 0, 1, 5, 0);
      apply("ld9",   0, 0, 1, 9, 0);
      apply("usub",  0, 0, 0, 0, 1);
      check("usub.a_const", a_out, 252);
      check("usub.err_const", err, 1);
      apply("uswap", 0, 0, 0, 0, 2);
      apply("uhold", 0, 0, 0, 0, 0);
      check("uhold.err_const", err, 1);
      apply("rel",   0, 0, 0, 0, 3);
      check("rel.err_const", err, 0);
      check("rel.in_ready_const", in_ready, 1);
      check("rel.dbg_state_empty", dbg_state, 0);

      // clr in HALF beats a simultaneous load
      apply("ld3",   0, 0, 1, 3, 0);
      apply("clrH",  0, 1, 1, 7, 0);
      check("clrH.a_const", a_out, 0);
      check("clrH.in_ready_const", in_ready, 1);

      // in_valid ignored in FULL
      apply("ldX",   0, 0, 1, 40, 0);
      apply("ldY",   0, 0, 1, 60, 0);
      apply("ign",   0, 0, 1, 99, 0);
      check("ign.a_const", a_out, 40);
      check("ign.b_const", b_out, 60);
      check("ign.in_ready_const", in_ready, 0);

      // zero operands: flag values in the cycle op_valid rises
      apply("rst3",  1, 0, 0, 0, 0);
      apply("ld0a",  0, 0, 1, 0, 0);
      apply("ld0b",  0, 0, 1, 0, 0);
`ifdef GCD_OPMUX_FLAGS_EN
      check("zero.b_zero_const", b_zero, 1);
`else
      check("zero.b_zero_const", b_zero, 0);
`endif
      check("zero.a_lt_b_const", a_lt_b, 0);

      // rst mid-operation, then randomized traffic
      apply("ldR",   0, 0, 1, 11, 0);
      apply("rstH",  1, 0, 1, 22, 1);
      for (int i = 0; i < 3000; i++) begin
         bit r, c, v;
         int d, k;
         r = ($urandom_range(0, 99) == 0);
         c = ($urandom_range(0, 39) == 0);
         v = ($urandom_range(0, 1) == 1);
         d = (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)));
         k = int'($urandom_range(0, 3));
         apply("rnd", r, c, v, d, k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
